// File: rtl/mux_rr_stream.sv
// N_CH-channel valid/ready stream multiplexer with static-select or round-robin arbitration.
// The output word, its valid flag and its source channel are all registered.
module mux_rr_stream #(
  parameter int unsigned N_CH  = 4,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CH_W  = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    mode,
  input  logic [CH_W-1:0]         sel,
  input  logic [N_CH-1:0]         in_valid,
  input  logic [N_CH*WIDTH-1:0]   in_data,
  output logic [N_CH-1:0]         in_ready,
  output logic                    out_valid,
  output logic [WIDTH-1:0]        out_data,
  output logic [CH_W-1:0]         out_ch,
  input  logic                    out_ready
);

  logic [CH_W-1:0]  r_ptr;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic [CH_W-1:0]  r_out_ch;

  logic             w_load;
  logic             w_gnt_vld;
  logic [CH_W-1:0]  w_gnt_idx;
  logic [CH_W-1:0]  w_rr_idx;
  logic [WIDTH-1:0] w_gnt_data;
  logic             w_xfer;

  assign w_load = !r_out_valid || out_ready;

  // Round-robin search runs from the farthest offset down so the nearest valid channel wins.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_idx = '0;
    w_rr_idx  = '0;
    if (!mode) begin
      if (int'(sel) < int'(N_CH)) begin
        w_gnt_vld = 1'b1;
        w_gnt_idx = sel;
      end
    end else begin
      for (int k = int'(N_CH) - 1; k >= 0; k--) begin
        w_rr_idx = CH_W'((int'(r_ptr) + k) % int'(N_CH));
        if (in_valid[w_rr_idx]) begin
          w_gnt_vld = 1'b1;
          w_gnt_idx = w_rr_idx;
        end
      end
    end
  end

  always_comb begin
    w_gnt_data = '0;
    for (int i = 0; i < int'(N_CH); i++) begin
      if (w_gnt_idx == CH_W'(i)) begin
        w_gnt_data = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    in_ready = '0;
    if (rst_n && w_gnt_vld && w_load) begin
      in_ready[w_gnt_idx] = 1'b1;
    end
  end

  assign w_xfer = rst_n && w_gnt_vld && w_load && in_valid[w_gnt_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr       <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_ch    <= '0;
    end else if (w_xfer) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_gnt_data;
      r_out_ch    <= w_gnt_idx;
      if (mode) begin
        r_ptr <= (w_gnt_idx == CH_W'(N_CH - 1)) ? '0 : w_gnt_idx + CH_W'(1);
      end
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_ch    = r_out_ch;

endmodule

// File: tb/tb_mux_rr_stream.sv
// Self-checking bench for mux_rr_stream: a behavioural model checked every cycle plus
// directed literal expectations for reset, static select, round-robin, backpressure and reset.
module tb_mux_rr_stream;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         mode;
  logic [1:0]   sel;
  logic [3:0]   in_valid;
  logic [31:0]  in_data;
  logic [3:0]   in_ready;
  logic         out_valid;
  logic [7:0]   out_data;
  logic [1:0]   out_ch;
  logic         out_ready;

  int vectors = 0;
  int miscompares = 0;

  mux_rr_stream #(.N_CH(4), .WIDTH(8), .CH_W(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .mode     (mode),
    .sel      (sel),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_ch   (out_ch),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state: what the registered output must hold, and the round-robin start point.
  logic       m_valid;
  logic [7:0] m_data;
  logic [1:0] m_ch;
  int         m_ptr;

  function automatic int grant(input logic md, input logic [1:0] s, input logic [3:0] v,
                               input int p);
    if (!md) return (int'(s) < N) ? int'(s) : -1;
    for (int k = 0; k < N; k++) begin
      if (v[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [3:0] exp_ready();
    int g;
    logic [3:0] r;
    r = 4'b0;
    g = grant(mode, sel, in_valid, m_ptr);
    if (rst_n && g >= 0 && (!m_valid || out_ready)) r[g] = 1'b1;
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    int g;
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_data  <= 8'h00;
      m_ch    <= 2'd0;
      m_ptr   <= 0;
    end else begin
      g = grant(mode, sel, in_valid, m_ptr);
      if (g >= 0 && (!m_valid || out_ready) && in_valid[g]) begin
        m_valid <= 1'b1;
        m_data  <= in_data[g*8 +: 8];
        m_ch    <= 2'(g);
        if (mode) m_ptr <= (g + 1) % N;
      end else if (out_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    chk("model in_ready", 32'(in_ready), 32'(exp_ready()));
    chk("model out_valid", 32'(out_valid), 32'(m_valid));
    chk("model out_data", 32'(out_data), 32'(m_data));
    chk("model out_ch", 32'(out_ch), 32'(m_ch));
  end

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string name, input logic v, input logic [7:0] d,
                         input logic [1:0] c);
    chk({name, " valid"}, 32'(out_valid), 32'(v));
    chk({name, " data"}, 32'(out_data), 32'(d));
    chk({name, " ch"}, 32'(out_ch), 32'(c));
  endtask

  initial begin
    logic [1:0] seq_a [4];
    seq_a = '{2'd1, 2'd3, 2'd1, 2'd3};
    rst_n = 1'b0; mode = 1'b1; sel = 2'd0; in_valid = 4'hF; out_ready = 1'b1;
    in_data = 32'h1312_1110;
    #3;
    chk_out("reset", 1'b0, 8'h00, 2'd0);
    chk("reset in_ready", 32'(in_ready), 32'h0);
    edge1(); edge1();
    chk_out("reset held", 1'b0, 8'h00, 2'd0);
    rst_n = 1'b1;
    #1;
    chk("first rr grant", 32'(in_ready), 32'h1);

    // All four valid: one word per cycle in order 0,1,2,3,0,1; leaves ptr at 2.
    for (int i = 0; i < 6; i++) begin
      edge1();
      chk_out("rr all", 1'b1, 8'(8'h10 + i % 4), 2'(i % 4));
    end

    // Static sel=0 for three transfers, pointer must not move.
    mode = 1'b0; sel = 2'd0;
    #1;
    chk("static sel0 ready", 32'(in_ready), 32'h1);
    for (int i = 0; i < 3; i++) begin
      edge1();
      chk_out("static ch0", 1'b1, 8'h10, 2'd0);
    end
    mode = 1'b1;
    #1;
    chk("rr resume ready", 32'(in_ready), 32'h4);
    edge1(); chk_out("rr resume a", 1'b1, 8'h12, 2'd2);
    edge1(); chk_out("rr resume b", 1'b1, 8'h13, 2'd3);

    // Only ch1 and ch3 valid, pointer back at 0.
    in_valid = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      edge1();
      chk("rr sparse ch", 32'(out_ch), 32'(seq_a[i]));
    end

    // Static select of ch2 with 8'hA5, then sel=3 with nothing valid.
    mode = 1'b0; sel = 2'd2; in_valid = 4'b0100; in_data[16 +: 8] = 8'hA5;
    #1;
    chk("static sel2 ready", 32'(in_ready), 32'h4);
    edge1(); chk_out("static a5", 1'b1, 8'hA5, 2'd2);
    sel = 2'd3; in_valid = 4'b0000;
    #1;
    chk("static sel3 ready", 32'(in_ready), 32'h8);
    edge1(); chk_out("static idle drain", 1'b0, 8'hA5, 2'd2);

    // Backpressure: hold ch0 word for five cycles, then drain and reload together.
    mode = 1'b1; in_valid = 4'b0001;
    edge1(); chk_out("bp load", 1'b1, 8'h10, 2'd0);
    out_ready = 1'b0; in_valid = 4'b0010;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp in_ready", 32'(in_ready), 32'h0);
      chk_out("bp hold", 1'b1, 8'h10, 2'd0);
      edge1();
    end
    out_ready = 1'b1;
    #1;
    chk("bp release ready", 32'(in_ready), 32'h2);
    edge1(); chk_out("bp reload", 1'b1, 8'h11, 2'd1);

    // Asynchronous reset with 8'h5A pending: clears without a clock edge.
    in_valid = 4'b0100; in_data[16 +: 8] = 8'h5A;
    edge1(); chk_out("pre reset", 1'b1, 8'h5A, 2'd2);
    out_ready = 1'b0; in_valid = 4'b0000;
    #2;
    rst_n = 1'b0;
    #1;
    chk_out("async reset", 1'b0, 8'h00, 2'd0);
    chk("async reset ready", 32'(in_ready), 32'h0);
    edge1();
    rst_n = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      edge1();
      chk_out("post reset", 1'b0, 8'h00, 2'd0);
    end
    in_valid = 4'hF;
    #1;
    chk("post reset grant", 32'(in_ready), 32'h1);
    edge1(); chk_out("post reset word", 1'b1, 8'h10, 2'd0);
    edge1();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
